// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and constants for the CPU-to-AXI3 bridge.
// State encodings, fixed AXI field values and transaction IDs.
package cpu_axi_bridge_pkg;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_AR   = 2'd1,
      R_R    = 2'd2
   } rd_state_e;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_REQ  = 2'd1,
      W_B    = 2'd2
   } wr_state_e;

   localparam logic [3:0] ID_INST   = 4'd0;
   localparam logic [3:0] ID_DATA   = 4'd1;
   localparam logic [3:0] ID_WRITE  = 4'd1;

   localparam logic [7:0] AXI_LEN   = 8'd0;
   localparam logic [1:0] AXI_BURST = 2'b01;
   localparam logic [1:0] AXI_LOCK  = 2'b00;
   localparam logic [3:0] AXI_CACHE = 4'b0000;
   localparam logic [2:0] AXI_PROT  = 3'b000;

endpackage

// File: rtl/cpu_axi_bridge.sv
// Bridges the CPU instruction and data request ports onto one AXI3 master.
// One outstanding read and one outstanding write; data reads beat instruction reads.
module cpu_axi_bridge
   import cpu_axi_bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  inst_req,
   input  logic                  inst_wr,
   input  logic [1:0]            inst_size,
   input  logic [ADDR_W-1:0]     inst_addr,
   input  logic [DATA_W/8-1:0]   inst_wstrb,
   input  logic [DATA_W-1:0]     inst_wdata,
   output logic                  inst_addr_ok,
   output logic                  inst_data_ok,
   output logic [DATA_W-1:0]     inst_rdata,
   input  logic                  data_req,
   input  logic                  data_wr,
   input  logic [1:0]            data_size,
   input  logic [ADDR_W-1:0]     data_addr,
   input  logic [DATA_W/8-1:0]   data_wstrb,
   input  logic [DATA_W-1:0]     data_wdata,
   output logic                  data_addr_ok,
   output logic                  data_data_ok,
   output logic [DATA_W-1:0]     data_rdata,
   output logic [3:0]            arid,
   output logic [ADDR_W-1:0]     araddr,
   output logic [7:0]            arlen,
   output logic [2:0]            arsize,
   output logic [1:0]            arburst,
   output logic [1:0]            arlock,
   output logic [3:0]            arcache,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [3:0]            rid,
   input  logic [DATA_W-1:0]     rdata,
   input  logic [1:0]            rresp,
   input  logic                  rlast,
   input  logic                  rvalid,
   output logic                  rready,
   output logic [3:0]            awid,
   output logic [ADDR_W-1:0]     awaddr,
   output logic [7:0]            awlen,
   output logic [2:0]            awsize,
   output logic [1:0]            awburst,
   output logic [1:0]            awlock,
   output logic [3:0]            awcache,
   output logic [2:0]            awprot,
   output logic                  awvalid,
   input  logic                  awready,
   output logic [3:0]            wid,
   output logic [DATA_W-1:0]     wdata,
   output logic [DATA_W/8-1:0]   wstrb,
   output logic                  wlast,
   output logic                  wvalid,
   input  logic                  wready,
   input  logic [3:0]            bid,
   input  logic [1:0]            bresp,
   input  logic                  bvalid,
   output logic                  bready
);

   rd_state_e             r_rst;
   wr_state_e             r_wst;
   logic                  r_data_busy;
   logic [3:0]            r_arid;
   logic [ADDR_W-1:0]     r_araddr;
   logic [1:0]            r_arsize;
   logic                  r_arvalid;
   logic                  r_rready;
   logic                  r_inst_dok;
   logic                  r_data_rdok;
   logic [DATA_W-1:0]     r_inst_rdata;
   logic [DATA_W-1:0]     r_data_rdata;
   logic [ADDR_W-1:0]     r_awaddr;
   logic [1:0]            r_awsize;
   logic [DATA_W/8-1:0]   r_wstrb;
   logic [DATA_W-1:0]     r_wdata;
   logic                  r_awvalid;
   logic                  r_wvalid;
   logic                  r_bready;
   logic                  r_data_wdok;

   logic w_rd_idle;
   logic w_data_rd_acc;
   logic w_data_wr_acc;
   logic w_inst_acc;
   logic w_aw_done;
   logic w_w_done;
   logic w_unused;

   // Data reads wait for any pending write so a read never overtakes it.
   assign w_rd_idle     = (r_rst == R_IDLE);
   assign w_data_rd_acc = resetn & data_req & ~data_wr & w_rd_idle
                        & ~r_data_busy & (r_wst == W_IDLE);
   assign w_data_wr_acc = resetn & data_req & data_wr
                        & (r_wst == W_IDLE) & ~r_data_busy;
   assign w_inst_acc    = resetn & inst_req & w_rd_idle & ~w_data_rd_acc;

   assign inst_addr_ok = w_inst_acc;
   assign data_addr_ok = w_data_rd_acc | w_data_wr_acc;
   assign inst_data_ok = r_inst_dok;
   assign data_data_ok = r_data_rdok | r_data_wdok;
   assign inst_rdata   = r_inst_rdata;
   assign data_rdata   = r_data_rdata;

   assign arid    = r_arid;
   assign araddr  = r_araddr;
   assign arlen   = AXI_LEN;
   assign arsize  = {1'b0, r_arsize};
   assign arburst = AXI_BURST;
   assign arlock  = AXI_LOCK;
   assign arcache = AXI_CACHE;
   assign arprot  = AXI_PROT;
   assign arvalid = r_arvalid;
   assign rready  = r_rready;

   assign awid    = ID_WRITE;
   assign awaddr  = r_awaddr;
   assign awlen   = AXI_LEN;
   assign awsize  = {1'b0, r_awsize};
   assign awburst = AXI_BURST;
   assign awlock  = AXI_LOCK;
   assign awcache = AXI_CACHE;
   assign awprot  = AXI_PROT;
   assign awvalid = r_awvalid;
   assign wid     = ID_WRITE;
   assign wdata   = r_wdata;
   assign wstrb   = r_wstrb;
   assign wlast   = 1'b1;
   assign wvalid  = r_wvalid;
   assign bready  = r_bready;

   assign w_unused = ^{inst_wr, inst_wstrb, inst_wdata, rresp, rlast, bid, bresp};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_rst        <= R_IDLE;
         r_arid       <= '0;
         r_araddr     <= '0;
         r_arsize     <= '0;
         r_arvalid    <= 1'b0;
         r_rready     <= 1'b0;
         r_inst_dok   <= 1'b0;
         r_data_rdok  <= 1'b0;
         r_inst_rdata <= '0;
         r_data_rdata <= '0;
      end else begin
         r_inst_dok  <= 1'b0;
         r_data_rdok <= 1'b0;
         unique case (r_rst)
            R_IDLE: begin
               if (w_data_rd_acc || w_inst_acc) begin
                  r_rst     <= R_AR;
                  r_arvalid <= 1'b1;
                  r_arid    <= w_data_rd_acc ? ID_DATA   : ID_INST;
                  r_araddr  <= w_data_rd_acc ? data_addr : inst_addr;
                  r_arsize  <= w_data_rd_acc ? data_size : inst_size;
               end
            end
            R_AR: begin
               if (arready) begin
                  r_rst     <= R_R;
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
               end
            end
            R_R: begin
               if (rvalid) begin
                  r_rst    <= R_IDLE;
                  r_rready <= 1'b0;
                  if (rid == ID_DATA) begin
                     r_data_rdok  <= 1'b1;
                     r_data_rdata <= rdata;
                  end else begin
                     r_inst_dok   <= 1'b1;
                     r_inst_rdata <= rdata;
                  end
               end
            end
            default: r_rst <= R_IDLE;
         endcase
      end
   end

   // A handshake counts as done once its valid has already dropped.
   assign w_aw_done = ~r_awvalid | awready;
   assign w_w_done  = ~r_wvalid  | wready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wst       <= W_IDLE;
         r_awaddr    <= '0;
         r_awsize    <= '0;
         r_wstrb     <= '0;
         r_wdata     <= '0;
         r_awvalid   <= 1'b0;
         r_wvalid    <= 1'b0;
         r_bready    <= 1'b0;
         r_data_wdok <= 1'b0;
      end else begin
         r_data_wdok <= 1'b0;
         unique case (r_wst)
            W_IDLE: begin
               if (w_data_wr_acc) begin
                  r_wst     <= W_REQ;
                  r_awaddr  <= data_addr;
                  r_awsize  <= data_size;
                  r_wstrb   <= data_wstrb;
                  r_wdata   <= data_wdata;
                  r_awvalid <= 1'b1;
                  r_wvalid  <= 1'b1;
               end
            end
            W_REQ: begin
               if (awready) r_awvalid <= 1'b0;
               if (wready)  r_wvalid  <= 1'b0;
               if (w_aw_done && w_w_done) begin
                  r_wst    <= W_B;
                  r_bready <= 1'b1;
               end
            end
            W_B: begin
               if (bvalid) begin
                  r_wst       <= W_IDLE;
                  r_bready    <= 1'b0;
                  r_data_wdok <= 1'b1;
               end
            end
            default: r_wst <= W_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)           r_data_busy <= 1'b0;
      else if (data_addr_ok) r_data_busy <= 1'b1;
      else if (data_data_ok) r_data_busy <= 1'b0;
   end

endmodule
